// File: rtl/des_perm_pipe.sv
// des_perm_pipe: elastic LATENCY-stage DES IP / FP / bypass permutation engine.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_mode/in_tag
//   ingress; out_valid/out_ready/out_data/out_tag/out_mode_err egress;
//   blk_count (accepted blocks, wraps); chk_err (sticky self-check error).
// Optional: define DES_PERM_SELFCHECK_EN to build the inverse-permutation
//   self-check; otherwise chk_err is tied 0.
module des_perm_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode_err,
    output logic [CNT_W-1:0] blk_count,
    output logic             chk_err
);

    // Tables list the source DES bit (1 = MSB) for each output bit.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[63-i] = x[64-IP_T[i]];
        end
        return r;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[63-i] = x[64-FP_T[i]];
        end
        return r;
    endfunction

    // Ingress permutation ahead of stage 0.
    logic [63:0] p_data;
    logic        p_err;

    always_comb begin
        p_data = in_data;
        p_err  = 1'b0;
        unique case (1'b1)
            (in_mode == 2'b00): p_data = perm_ip(in_data);
            (in_mode == 2'b01): p_data = perm_fp(in_data);
            (in_mode == 2'b11): p_err  = 1'b1;
            default:            p_data = in_data;
        endcase
    end

    // Stage registers.
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] e_q;
    logic [63:0]        d_q [LATENCY];
    logic [TAG_W-1:0]   t_q [LATENCY];

    // Per-stage source (stage 0 from ingress, stage k from k-1).
    logic [LATENCY-1:0] s_v;
    logic [LATENCY-1:0] s_e;
    logic [63:0]        s_d [LATENCY];
    logic [TAG_W-1:0]   s_t [LATENCY];

    always_comb begin
        s_v    = '0;
        s_e    = '0;
        s_v[0] = in_valid;
        s_e[0] = p_err;
        s_d[0] = p_data;
        s_t[0] = in_tag;
        for (int k = 1; k < LATENCY; k++) begin
            s_v[k] = v_q[k-1];
            s_e[k] = e_q[k-1];
            s_d[k] = d_q[k-1];
            s_t[k] = t_q[k-1];
        end
    end

    // A stage loads when it, or any stage after it, has room,
    // or when the tail drains this cycle.
    logic [LATENCY-1:0] ld;

    always_comb begin : load_chain
        logic go;
        go = out_ready;
        ld = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            go    = go | ~v_q[k];
            ld[k] = go;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            e_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                d_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (ld[k]) begin
                    v_q[k] <= s_v[k];
                    e_q[k] <= s_e[k];
                    d_q[k] <= s_d[k];
                    t_q[k] <= s_t[k];
                end
            end
        end
    end

    assign in_ready     = ld[0];
    assign out_valid    = v_q[LATENCY-1];
    assign out_data     = d_q[LATENCY-1];
    assign out_tag      = t_q[LATENCY-1];
    assign out_mode_err = e_q[LATENCY-1];

    // Accepted-block counter, wraps.
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (in_valid && in_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign blk_count = cnt_q;

`ifdef DES_PERM_SELFCHECK_EN
    // Original block and mode ride alongside the permuted data.
    logic [63:0] o_q [LATENCY];
    logic [1:0]  m_q [LATENCY];
    logic [63:0] s_o [LATENCY];
    logic [1:0]  s_m [LATENCY];

    always_comb begin
        s_o[0] = in_data;
        s_m[0] = in_mode;
        for (int k = 1; k < LATENCY; k++) begin
            s_o[k] = o_q[k-1];
            s_m[k] = m_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                o_q[k] <= '0;
                m_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (ld[k]) begin
                    o_q[k] <= s_o[k];
                    m_q[k] <= s_m[k];
                end
            end
        end
    end

    // Undo the forward permutation and compare with the original.
    logic [63:0] inv_data;

    always_comb begin
        inv_data = out_data;
        unique case (1'b1)
            (m_q[LATENCY-1] == 2'b00): inv_data = perm_fp(out_data);
            (m_q[LATENCY-1] == 2'b01): inv_data = perm_ip(out_data);
            default:                   inv_data = out_data;
        endcase
    end

    logic chk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
        end else if (out_valid && out_ready
                     && (inv_data != o_q[LATENCY-1])) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb_des_perm_pipe: randomized self-checking bench for des_perm_pipe.
// Reference model builds the DES tables arithmetically and scoreboards output.
module tb_des_perm_pipe;

    localparam int L  = 2;
    localparam int TW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          out_mode_err;
    logic [CW-1:0] blk_count;
    logic          chk_err;

    always #5 clk = ~clk;

    des_perm_pipe #(
        .LATENCY (L),
        .TAG_W   (TW),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_mode_err (out_mode_err),
        .blk_count    (blk_count),
        .chk_err      (chk_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int ip_t [64];
    int fp_t [64];

    typedef struct {
        logic [63:0]   d;
        logic [TW-1:0] t;
        logic          e;
    } exp_t;

    exp_t sb [$];

    // IP rows: even source bits 58..64 then odd 57..63, stepping down by 8.
    // FP is built as the inverse of IP.
    task automatic build_tables();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                ip_t[8*r+c] = ((r < 4) ? 58 + 2*r : 57 + 2*(r-4)) - 8*c;
            end
        end
        for (int i = 0; i < 64; i++) fp_t[ip_t[i]-1] = i + 1;
    endtask

    function automatic logic [63:0] model(input logic [63:0] x,
                                          input logic [1:0] m);
        logic [63:0] r;
        r = x;
        if (m == 2'b00)
            for (int i = 0; i < 64; i++) r[63-i] = x[64-ip_t[i]];
        else if (m == 2'b01)
            for (int i = 0; i < 64; i++) r[63-i] = x[64-fp_t[i]];
        return r;
    endfunction

    function automatic exp_t mk(input logic [63:0] d, input logic [1:0] m,
                                input logic [TW-1:0] t);
        exp_t x;
        x.d = model(d, m);
        x.t = t;
        x.e = (m == 2'b11);
        return x;
    endfunction

    // Present inputs for one cycle and settle before the next edge.
    task automatic drive(input logic v, input logic [63:0] d,
                         input logic [1:0] m, input logic [TW-1:0] t,
                         input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_tag    = t;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acc_cnt = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_mode_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b/%b want 0/0",
                     out_valid, out_mode_err);
        end
        n_tests++;
        if (blk_count !== '0 || chk_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%b want 0/0",
                     blk_count, chk_err);
        end
        n_tests++;
        if (out_data !== '0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h want 0/0",
                     out_data, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [63:0]   vd [3];
        logic [63:0]   ve [3];
        logic [1:0]    vm [3];
        logic [TW-1:0] vt [3];
        int n;
        vd[0] = 64'h0123456789ABCDEF; vm[0] = 2'b00;
        ve[0] = 64'hCC00CCFFF0AAF0AA; vt[0] = 4'h5;
        vd[1] = 64'hCC00CCFFF0AAF0AA; vm[1] = 2'b01;
        ve[1] = 64'h0123456789ABCDEF; vt[1] = 4'h6;
        vd[2] = 64'h8000000000000000; vm[2] = 2'b00;
        ve[2] = 64'h0000000001000000; vt[2] = 4'h7;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vd[i], vm[i], vt[i], 1'b1);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec_accept: got %b want 1", in_ready);
            end
            if (in_ready === 1'b1) acc_cnt++;
            n = 0;
            do begin
                drive(1'b0, '0, 2'b00, '0, 1'b1);
                n++;
            end while (out_valid !== 1'b1 && n < 10);
            n_tests++;
            if (n != L) begin
                n_fail++;
                $display("FAIL vec_latency: got %0d want %0d", n, L);
            end
            n_tests++;
            if (out_data !== ve[i]) begin
                n_fail++;
                $display("FAIL vec_data: got %h want %h", out_data, ve[i]);
            end
            n_tests++;
            if (out_tag !== vt[i] || out_mode_err !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_tag: got %h/%b want %h/0",
                         out_tag, out_mode_err, vt[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        logic [63:0] d;
        logic [1:0]  m;
        do_reset();
        while (rcvd < 8 && cyc < 60) begin
            d = {$urandom, $urandom};
            m = 2'($urandom_range(0, 2));
            drive(sent < 8, d, m, TW'(sent), cyc >= 5);
            if (cyc < 5) begin
                n_tests++;
                if (in_ready !== (sent < L)) begin
                    n_fail++;
                    $display("FAIL bp_ready: cyc %0d got %b want %b",
                             cyc, in_ready, sent < L);
                end
            end else begin
                n_tests++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_thru: cyc %0d got %b want 1",
                             cyc, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got tag %h want none", out_tag);
                end else if (out_data !== sb[0].d || out_tag !== sb[0].t
                             || out_mode_err !== sb[0].e) begin
                    n_fail++;
                    $display("FAIL bp_data: got %h/%h want %h/%h",
                             out_data, out_tag, sb[0].d, sb[0].t);
                end
                if (out_ready && sb.size() > 0) begin
                    void'(sb.pop_front());
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(mk(d, m, TW'(sent)));
                sent++;
                acc_cnt++;
            end
            cyc++;
        end
        n_tests++;
        if (rcvd != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 8", rcvd);
        end
        n_tests++;
        if (blk_count !== CW'(8)) begin
            n_fail++;
            $display("FAIL bp_blk: got %0d want 8", blk_count);
        end
    endtask

    task automatic test_mode_err();
        logic [63:0]   bd [2];
        logic [1:0]    bm [2];
        logic [TW-1:0] bt [2];
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        bd[0] = 64'hDEADBEEF00112233; bm[0] = 2'b11; bt[0] = 4'hA;
        bd[1] = {$urandom, $urandom}; bm[1] = 2'b10; bt[1] = 4'hB;
        while (rcvd < 2 && cyc < 30) begin
            if (sent < 2)
                drive(1'b1, bd[sent], bm[sent], bt[sent], 1'b1);
            else
                drive(1'b0, '0, 2'b00, '0, 1'b1);
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL merr_extra: got tag %h want none", out_tag);
                end else if (out_data !== sb[0].d || out_tag !== sb[0].t
                             || out_mode_err !== sb[0].e) begin
                    n_fail++;
                    $display("FAIL merr_blk: got %h/%h/%b want %h/%h/%b",
                             out_data, out_tag, out_mode_err,
                             sb[0].d, sb[0].t, sb[0].e);
                end
                if (out_tag === 4'hA) begin
                    n_tests++;
                    if (out_data !== 64'hDEADBEEF00112233
                        || out_mode_err !== 1'b1) begin
                        n_fail++;
                        $display("FAIL merr_11: got %h/%b want %h/1",
                                 out_data, out_mode_err,
                                 64'hDEADBEEF00112233);
                    end
                end
                if (sb.size() > 0) void'(sb.pop_front());
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(mk(bd[sent], bm[sent], bt[sent]));
                sent++;
                acc_cnt++;
            end
            cyc++;
        end
        n_tests++;
        if (rcvd != 2) begin
            n_fail++;
            $display("FAIL merr_count: got %0d want 2", rcvd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int stale = 0;
        logic [63:0] d;
        do_reset();
        drive(1'b1, {$urandom, $urandom}, 2'b00, 4'h1, 1'b0);
        drive(1'b1, {$urandom, $urandom}, 2'b01, 4'h2, 1'b0);
        drive(1'b0, '0, 2'b00, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || blk_count !== '0) begin
            n_fail++;
            $display("FAIL rmid_clear: got %b/%0d want 0/0",
                     out_valid, blk_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        acc_cnt = 0;
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 2'b00, '0, 1'b1);
            if (out_valid !== 1'b0) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rmid_stale: got %0d valid cycles want 0", stale);
        end
        d = {$urandom, $urandom};
        drive(1'b1, d, 2'b00, 4'h3, 1'b1);
        if (in_ready === 1'b1) acc_cnt++;
        n = 0;
        do begin
            drive(1'b0, '0, 2'b00, '0, 1'b1);
            n++;
        end while (out_valid !== 1'b1 && n < 10);
        n_tests++;
        if (n != L || out_data !== model(d, 2'b00) || out_tag !== 4'h3) begin
            n_fail++;
            $display("FAIL rmid_new: got lat %0d %h/%h want %0d %h/3",
                     n, out_data, out_tag, L, model(d, 2'b00));
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        do_reset();
        while (sent < 17 && cyc < 80) begin
            drive(1'b1, {$urandom, $urandom}, 2'b00, TW'(sent), 1'b1);
            if (in_ready === 1'b1) begin
                sent++;
                acc_cnt++;
            end
            cyc++;
        end
        repeat (L + 2) drive(1'b0, '0, 2'b00, '0, 1'b1);
        n_tests++;
        if (sent != 17) begin
            n_fail++;
            $display("FAIL wrap_sent: got %0d want 17", sent);
        end
        n_tests++;
        if (blk_count !== CW'(acc_cnt) || blk_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL wrap_cnt: got %0d want %0d",
                     blk_count, acc_cnt % (1 << CW));
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc  = 0;
        logic v;
        logic r;
        logic [63:0]   d;
        logic [1:0]    m;
        logic [TW-1:0] t;
        while ((sent < 1000 || sb.size() > 0) && cyc < 8000) begin
            v = (sent < 1000) && ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            d = {$urandom, $urandom};
            m = 2'($urandom_range(0, 3));
            t = TW'($urandom);
            drive(v, d, m, t, r);
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: got tag %h want none", out_tag);
                end else if (out_data !== sb[0].d || out_tag !== sb[0].t
                             || out_mode_err !== sb[0].e) begin
                    n_fail++;
                    $display("FAIL rnd_blk: got %h/%h/%b want %h/%h/%b",
                             out_data, out_tag, out_mode_err,
                             sb[0].d, sb[0].t, sb[0].e);
                end
                if (r && sb.size() > 0) void'(sb.pop_front());
            end
            if (v && in_ready) begin
                sb.push_back(mk(d, m, t));
                sent++;
                acc_cnt++;
            end
            cyc++;
        end
        n_tests++;
        if (sent != 1000 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_done: got %0d sent %0d left want 1000/0",
                     sent, sb.size());
        end
        n_tests++;
        if (blk_count !== CW'(acc_cnt)) begin
            n_fail++;
            $display("FAIL rnd_cnt: got %0d want %0d",
                     blk_count, acc_cnt % (1 << CW));
        end
        n_tests++;
        if (chk_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_chk: got %b want 0", chk_err);
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_mode_err();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Pipelined, mode-selectable DES bit-permutation engine. It replaces the purely combinational initial-permutation logic in the datapath.
- Each 64-bit block can have one of three permutations applied: IP, FP (IP inverse), or bypass.
- Ingress and egress use valid/ready handshakes. A user tag travels with each block.
- It sits between the serial-receive block assembler and the round pipeline (IP). A second instance sits between the round pipeline and the serial transmitter (FP).

Parameters:
- LATENCY, 2, number of register stages from accept to output valid (legal 1..4).
- TAG_W, 4, width of the sideband tag carried with each block.
- CNT_W, 16, width of the accepted-block counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input block valid.
- in_ready  output  1  engine can accept a block this cycle.
- in_data  input  64  block; DES bit 1 = in_data[63].
- in_mode  input  2  00 = IP, 01 = FP, 10 = bypass, 11 = reserved.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output block valid.
- out_ready  input  1  downstream accepts.
- out_data  output  64  permuted block.
- out_tag  output  TAG_W  tag of out_data.
- out_mode_err  output  1  this block was issued with mode 11.
- blk_count  output  CNT_W  blocks accepted since reset.
- chk_err  output  1  sticky self-check failure (see Optional Feature).

Behaviour:
- Permutation rule: for DES table T, out bit (64-i) = in bit (64-T[i]), i = 1..64.
  - IP uses the standard DES IP table.
  - FP uses the standard IP^-1 table.
  - Mode 11 passes data unpermuted (as bypass) and sets out_mode_err for that block only.
- The permutation is applied combinationally ahead of stage 0. Data, tag, mode-err and a per-stage valid bit then shift through LATENCY register stages.
- Elastic pipeline:
  - Stage k loads when it is empty or stage k+1 will load or drain this cycle.
  - Last stage drains when out_valid && out_ready.
  - in_ready = stage 0 will load. It is combinational from out_ready (no skid buffer).
- Throughput is 1 block/cycle while out_ready = 1. With an empty pipe, latency from accepting edge to out_valid is exactly LATENCY cycles.
- Backpressure:
  - While out_ready = 0, the pipe fills. in_ready drops once all LATENCY stages hold data.
  - No block is dropped, duplicated or reordered.
  - out_data, out_tag and out_mode_err are held stable while out_valid && !out_ready.
- Simultaneous drain and accept with a full pipe: both occur in the same cycle, and occupancy stays at LATENCY.
- blk_count increments on every in_valid && in_ready. It wraps modulo 2^CNT_W with no saturation.
- in_data, in_mode and in_tag are don't-care when in_valid = 0. Values in invalid stages are don't-care but are not X-gated.
- Reset (asynchronous assert, synchronous deassert in the surrounding design):
  - All stage valids = 0, out_valid = 0, out_mode_err = 0, blk_count = 0, chk_err = 0.
  - in_ready = 1 in the first cycle after reset.
  - Data and tag registers are also cleared to 0.
  - Reset mid-operation discards all in-flight blocks with no output.

Optional Feature:
- Macro: DES_PERM_SELFCHECK_EN.
- Defined:
  - Each stage also carries the original input block and mode.
  - At the last stage, the inverse permutation is applied to out_data (IP^-1 for IP blocks, IP for FP blocks, identity for bypass and mode 11).
  - The result is compared to the carried original. On a mismatch for a block transferred (out_valid && out_ready), chk_err sets and stays set until reset.
- Undefined: the extra registers are not built, and chk_err is tied 0.

Test Plan:
- IP: in_data 0x0123456789ABCDEF, mode 00, tag 0x5, out_ready = 1 → exactly LATENCY cycles later out_data 0xCC00CCFFF0AAF0AA, out_tag 0x5, out_mode_err 0.
- FP: in_data 0xCC00CCFFF0AAF0AA, mode 01 → 0x0123456789ABCDEF. Single-bit: in_data 0x8000000000000000, mode 00 → 0x0000000001000000.
- Streaming with backpressure:
  - Send 8 back-to-back blocks with tags 0..7 and hold out_ready = 0 for 5 cycles.
  - in_ready drops after LATENCY accepts, and outputs stay stable while stalled.
  - After release, all 8 blocks emerge in order, with 1/cycle throughput and blk_count = 8.
- Mode 11 with in_data 0xDEADBEEF00112233 → out_data unchanged, out_mode_err = 1 for that block only. The following mode-10 block has out_mode_err = 0.
- Reset mid-stream: assert rst_n = 0 with 2 blocks in flight → out_valid = 0 immediately and blk_count = 0. After release, no stale block appears, and a new block has latency LATENCY.
- Wrap: with CNT_W = 4, accept 17 blocks → blk_count = 1. With DES_PERM_SELFCHECK_EN defined, run 1000 random IP/FP blocks → chk_err stays 0.
